// File: rtl/store_rmw_unit_pkg.sv
// Shared encodings for the store path: width selects (also used by the load-side
// selector) and the store sequencer states.
package store_rmw_unit_pkg;

    localparam logic [1:0] SEL_WORD  = 2'b00;
    localparam logic [1:0] SEL_BYTE  = 2'b01;
    localparam logic [1:0] SEL_HALF  = 2'b10;
    localparam logic [1:0] SEL_UHALF = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_MERGE = 2'b10,
        ST_WRITE = 2'b11
    } state_e;

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge: inserts the store data into the old memory word
// according to the width select, and flags alignment violations.
module store_merge
    import store_rmw_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  select,
    input  logic [1:0]  addr,
    output logic [31:0] merged,
    output logic        misaligned
);

    logic [31:0] byte_merged;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_merged[8*gi +: 8] = (addr == 2'(gi)) ? data[7:0] : old_word[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        merged     = old_word;
        misaligned = 1'b0;
        case (select)
            SEL_WORD: begin
                merged     = data;
                misaligned = (addr != 2'b00);
            end
            SEL_BYTE: begin
                merged = byte_merged;
            end
            SEL_HALF: begin
                // Low halfword of the register lands in whichever half the address picks
                if (addr[1]) merged[31:16] = data[15:0];
                else         merged[15:0]  = data[15:0];
                misaligned = addr[0];
            end
            default: begin
                merged[31:16] = data[31:16];
            end
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Store sequencer: word stores write directly, byte/halfword stores read the
// target word, merge the new lanes and write it back.
module store_rmw_unit
    import store_rmw_unit_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_req,
    input  logic [31:0]       st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        store_select,
    output logic              st_ready,
    output logic              st_done,
    output logic              st_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    state_e            state_q, state_d;
    logic [MEM_AW+1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       old_q, old_d;
    logic [1:0]        sel_q, sel_d;
    logic              err_q, err_d;

    logic [31:0] m_data;
    logic [1:0]  m_sel;
    logic [1:0]  m_addr;
    logic [31:0] merged;
    logic        misaligned;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^st_addr[31:MEM_AW+2];

    // While idle the merger sees the live request (alignment check); afterwards
    // it sees the latched request (merged write word).
    always_comb begin
        m_data = data_q;
        m_sel  = sel_q;
        m_addr = addr_q[1:0];
        if (state_q == ST_IDLE) begin
            m_data = st_data;
            m_sel  = store_select;
            m_addr = st_addr[1:0];
        end
    end

    store_merge u_merge (
        .old_word   (old_q),
        .data       (m_data),
        .select     (m_sel),
        .addr       (m_addr),
        .merged     (merged),
        .misaligned (misaligned)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        old_d   = old_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (st_req) begin
                    addr_d = st_addr[MEM_AW+1:0];
                    data_d = st_data;
                    sel_d  = store_select;
                    if (misaligned)                    err_d   = 1'b1;
                    else if (store_select == SEL_WORD) state_d = ST_WRITE;
                    else                               state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_MERGE;
            ST_MERGE: begin
                old_d   = mem_rdata;
                state_d = ST_WRITE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            old_q   <= '0;
            sel_q   <= SEL_WORD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            old_q   <= old_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    assign st_ready  = (state_q == ST_IDLE);
    assign st_done   = (state_q == ST_WRITE);
    assign st_err    = err_q;
    assign mem_re    = (state_q == ST_READ);
    assign mem_we    = (state_q == ST_WRITE);
    assign mem_addr  = addr_q[MEM_AW+1:2];
    assign mem_wdata = (state_q == ST_WRITE) ? merged : 32'h0;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Self-checking bench for store_rmw_unit: directed cases plus random stores
// checked against a lane-mask reference model and a shadow memory.
module tb_store_rmw_unit;

    localparam int MEM_AW = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              st_req;
    logic [31:0]       st_addr;
    logic [31:0]       st_data;
    logic [1:0]        store_select;
    logic              st_ready;
    logic              st_done;
    logic              st_err;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    logic [31:0] ram     [0:(1<<MEM_AW)-1];
    logic [31:0] ref_mem [0:(1<<MEM_AW)-1];

    int n_tests = 0;
    int n_fail  = 0;

    store_rmw_unit #(.MEM_AW(MEM_AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .st_req       (st_req),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .store_select (store_select),
        .st_ready     (st_ready),
        .st_done      (st_done),
        .st_err       (st_err),
        .mem_addr     (mem_addr),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata)
    );

    always #5 clk = ~clk;

    // Data memory with one-cycle synchronous read
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic bit ref_misaligned(input logic [1:0] sel, input logic [1:0] a);
        return (sel == 2'b00 && a != 2'b00) || (sel == 2'b10 && a[0]);
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] sel, input logic [1:0] a);
        logic [31:0] mask;
        logic [31:0] ins;
        int sh;
        case (sel)
            2'b00: return d;
            2'b01: begin
                sh   = 8 * int'(a);
                mask = 32'hFF << sh;
                ins  = (d & 32'hFF) << sh;
            end
            2'b10: begin
                sh   = a[1] ? 16 : 0;
                mask = 32'hFFFF << sh;
                ins  = (d & 32'hFFFF) << sh;
            end
            default: begin
                mask = 32'hFFFF0000;
                ins  = d & mask;
            end
        endcase
        return (old & ~mask) | ins;
    endfunction

    task automatic preset(input int idx, input logic [31:0] val);
        @(negedge clk);
        ram[idx]     = val;
        ref_mem[idx] = val;
    endtask

    task automatic store_txn(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sel);
        int          widx = int'(addr[MEM_AW+1:2]);
        bit          mis  = ref_misaligned(sel, addr[1:0]);
        logic [31:0] exp_w = ref_merge(ref_mem[widx], data, sel, addr[1:0]);
        int re_cyc = -1, we_cyc = -1, done_cyc = -1, err_cyc = -1;
        int re_n = 0, we_n = 0, done_n = 0, err_n = 0, both = 0;
        logic [31:0] wd = 0, wa = 0, ra = 0;
        logic        rdy1 = 0;
        @(negedge clk);
        check("ready_before", 32'(st_ready), 32'd1);
        st_req = 1'b1; st_addr = addr; st_data = data; store_select = sel;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                st_req = 1'b0;
                rdy1 = st_ready;
            end
            if (mem_re && mem_we) both++;
            if (mem_re)  begin re_n++;  if (re_cyc < 0) re_cyc = k; ra = 32'(mem_addr); end
            if (mem_we)  begin we_n++;  if (we_cyc < 0) we_cyc = k; wd = mem_wdata; wa = 32'(mem_addr); end
            if (st_done) begin done_n++; if (done_cyc < 0) done_cyc = k; end
            if (st_err)  begin err_n++; if (err_cyc < 0) err_cyc = k; end
        end
        $display("[TB] store addr=%08h sel=%0b data=%08h mis=%0d re@%0d we@%0d wdata=%08h exp=%08h",
                 addr, sel, data, mis, re_cyc, we_cyc, wd, exp_w);
        check("re_we_overlap", 32'(both), 32'd0);
        if (mis) begin
            check("err_count", 32'(err_n), 32'd1);
            check("err_cycle", 32'(err_cyc), 32'd1);
            check("err_ready", 32'(rdy1), 32'd1);
            check("err_no_re", 32'(re_n), 32'd0);
            check("err_no_we", 32'(we_n), 32'd0);
        end else begin
            check("err_none", 32'(err_n), 32'd0);
            check("we_count", 32'(we_n), 32'd1);
            check("done_count", 32'(done_n), 32'd1);
            check("we_cycle", 32'(we_cyc), (sel == 2'b00) ? 32'd1 : 32'd3);
            check("done_cycle", 32'(done_cyc), 32'(we_cyc));
            check("re_count", 32'(re_n), (sel == 2'b00) ? 32'd0 : 32'd1);
            if (sel != 2'b00) begin
                check("re_cycle", 32'(re_cyc), 32'd1);
                check("re_addr", ra, 32'(widx));
            end
            check("we_addr", wa, 32'(widx));
            check("wdata", wd, exp_w);
            ref_mem[widx] = exp_w;
        end
    endtask

    initial begin
        int we_seen;
        int first_we, second_we;
        logic rdy3, rdy4;

        for (int i = 0; i < (1 << MEM_AW); i++) begin
            ram[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        reset = 1'b1; st_req = 1'b0; st_addr = 0; st_data = 0; store_select = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(st_ready), 32'd1);
        check("rst_outs", {26'd0, st_done, st_err, mem_re, mem_we, 2'b00}, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        // Directed cases
        preset(4, 32'hAAAAAAAA); store_txn(32'h10, 32'h12345678, 2'b00);
        preset(4, 32'hAABBCCDD); store_txn(32'h12, 32'h000000EE, 2'b01);
        preset(4, 32'hAABBCCDD); store_txn(32'h12, 32'h0000BEEF, 2'b10);
        preset(4, 32'hAABBCCDD); store_txn(32'h10, 32'hCAFE0000, 2'b11);
        store_txn(32'h11, 32'h11111111, 2'b00);
        store_txn(32'h13, 32'h22222222, 2'b10);
        check("mis_mem_intact", ram[4], 32'hCAFECCDD);

        // Reset asserted while the byte store sits in MERGE
        preset(4, 32'hAABBCCDD);
        @(negedge clk);
        st_req = 1'b1; st_addr = 32'h12; st_data = 32'hEE; store_select = 2'b01;
        @(negedge clk);
        st_req = 1'b0;
        @(negedge clk);
        check("merge_busy", 32'(st_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("arst_ready", 32'(st_ready), 32'd1);
        check("arst_outs", {26'd0, st_done, st_err, mem_re, mem_we, 2'b00}, 32'd0);
        check("arst_addr", 32'(mem_addr), 32'd0);
        check("arst_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        we_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_we || st_done) we_seen++;
        end
        $display("[TB] reset-in-merge abandon: stray writes=%0d mem[4]=%08h", we_seen, ram[4]);
        check("arst_no_write", 32'(we_seen), 32'd0);
        check("arst_mem_intact", ram[4], 32'hAABBCCDD);
        store_txn(32'h10, 32'h0BADF00D, 2'b00);

        // Back-to-back byte stores with st_req held high
        preset(8, 32'h0);
        @(negedge clk);
        st_req = 1'b1; st_addr = 32'h20; st_data = 32'h11; store_select = 2'b01;
        first_we = -1; second_we = -1; rdy3 = 1'b1; rdy4 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin st_addr = 32'h23; st_data = 32'h44; end
            if (k == 3) rdy3 = st_ready;
            if (k == 4) rdy4 = st_ready;
            if (k == 5) st_req = 1'b0;
            if (mem_we) begin
                if (first_we < 0) first_we = k;
                else if (second_we < 0) second_we = k;
            end
        end
        $display("[TB] back-to-back: we@%0d,%0d mem[8]=%08h", first_we, second_we, ram[8]);
        check("b2b_ready_in_write", 32'(rdy3), 32'd0);
        check("b2b_ready_after", 32'(rdy4), 32'd1);
        check("b2b_first_we", 32'(first_we), 32'd3);
        check("b2b_second_we", 32'(second_we), 32'd7);
        check("b2b_mem", ram[8], 32'h44000011);
        ref_mem[8] = 32'h44000011;

        // Random stores over a small window so read-modify-write sees prior writes
        for (int t = 0; t < 40; t++) begin
            logic [31:0] ra;
            ra = {27'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
            store_txn(ra, $urandom, 2'($urandom));
        end
        for (int i = 0; i < 8; i++) check("final_mem", ram[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
